// File: rtl/fifo_mailbox_bridge.sv
// Host<->user mailbox: NCH channel pairs of outbound/inbound FIFOs behind a
// single-beat register interface, with per-channel status and sticky OVF/UNF.

module fifo_mailbox_bridge_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [DW-1:0]            i_din,
    input  logic                     i_pop,
    output logic [DW-1:0]            o_dout,
    output logic [$clog2(DEPTH):0]   o_cnt,
    output logic                     o_full,
    output logic                     o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [AW:0]   r_cnt;
    logic          w_do_push, w_do_pop;

    // Drop decisions use pre-edge full/empty, so a push to a full FIFO is lost even with a same-cycle pop.
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push && !o_full && !i_flush;
    assign w_do_pop  = i_pop && !o_empty && !i_flush;
    assign o_dout    = r_mem[r_rp];
    assign o_cnt     = r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (i_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            if (w_do_push && !w_do_pop)      r_cnt <= r_cnt + 1'b1;
            else if (w_do_pop && !w_do_push) r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wp] <= i_din;
    end
endmodule

module fifo_mailbox_bridge #(
    parameter int          NCH        = 2,
    parameter int          DW         = 32,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0510,
    parameter logic [31:0] EMPTY_DATA = 32'hdead_0000
) (
    input  logic                clk_main_a0,
    input  logic                rst_main_n_sync,
    input  logic                wready,
    input  logic [31:0]         wr_addr,
    input  logic [DW-1:0]       wdata,
    input  logic                arvalid_q,
    input  logic [31:0]         araddr_q,
    input  logic                rready,
    output logic                rvalid,
    output logic [DW-1:0]       rdata,
    output logic [1:0]          rresp,
    output logic [NCH-1:0]      to_user_valid,
    output logic [NCH*DW-1:0]   to_user_data,
    input  logic [NCH-1:0]      to_user_ready,
    input  logic [NCH-1:0]      from_user_valid,
    input  logic [NCH*DW-1:0]   from_user_data,
    output logic [NCH-1:0]      from_user_ready
);
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic {S_IDLE, S_RESP} state_t;
    state_t r_state, w_state_nxt;

    logic [NCH-1:0][DW-1:0] w_out_dout, w_in_dout, w_status;
    logic [NCH-1:0][CW-1:0] w_out_cnt, w_in_cnt;
    logic [NCH-1:0]         w_out_full, w_out_empty, w_in_full, w_in_empty;
    logic [NCH-1:0]         w_in_pop, w_flush, w_ovf, w_unf;

    logic           w_rd_acc, w_rd_data, w_rd_stat, w_resp_err;
    logic [CHW-1:0] w_rd_ch;
    logic [DW-1:0]  w_resp_data, r_rdata;
    logic [1:0]     r_rresp;

    assign w_rd_acc = (r_state == S_IDLE) && arvalid_q;

    // Only exact DATA/STATUS addresses hit; CTRL, misaligned and out-of-range reads fall to SLVERR.
    always_comb begin
        w_rd_data = 1'b0;
        w_rd_stat = 1'b0;
        w_rd_ch   = '0;
        for (int c = 0; c < NCH; c++) begin
            if (araddr_q == BASE_ADDR + 32'(16*c)) begin
                w_rd_data = 1'b1;
                w_rd_ch   = CHW'(c);
            end
            if (araddr_q == BASE_ADDR + 32'(16*c + 4)) begin
                w_rd_stat = 1'b1;
                w_rd_ch   = CHW'(c);
            end
        end
    end

    always_comb begin
        w_resp_data = DW'(32'haaaa_aaaa);
        w_resp_err  = 1'b1;
        if (w_rd_data) begin
            w_resp_err  = 1'b0;
            w_resp_data = w_in_empty[w_rd_ch] ? DW'(EMPTY_DATA) : w_in_dout[w_rd_ch];
        end else if (w_rd_stat) begin
            w_resp_err  = 1'b0;
            w_resp_data = w_status[w_rd_ch];
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        localparam logic [31:0] A = BASE_ADDR + 32'(16*c);
        logic w_wr_data, w_wr_ctrl, w_rd_hit;
        logic r_ovf, r_unf;

        assign w_wr_data  = wready && (wr_addr == A);
        assign w_wr_ctrl  = wready && (wr_addr == A + 32'd8);
        assign w_rd_hit   = w_rd_acc && w_rd_data && (w_rd_ch == CHW'(c));
        assign w_flush[c] = w_wr_ctrl && wdata[1];
        assign w_in_pop[c] = w_rd_hit && !w_in_empty[c];
        assign w_ovf[c]   = r_ovf;
        assign w_unf[c]   = r_unf;

        fifo_mailbox_bridge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_out (
            .i_clk(clk_main_a0), .i_rst_n(rst_main_n_sync), .i_flush(w_flush[c]),
            .i_push(w_wr_data), .i_din(wdata), .i_pop(to_user_ready[c]),
            .o_dout(w_out_dout[c]), .o_cnt(w_out_cnt[c]),
            .o_full(w_out_full[c]), .o_empty(w_out_empty[c])
        );

        fifo_mailbox_bridge_fifo #(.DW(DW), .DEPTH(DEPTH)) u_in (
            .i_clk(clk_main_a0), .i_rst_n(rst_main_n_sync), .i_flush(w_flush[c]),
            .i_push(from_user_valid[c]), .i_din(from_user_data[c*DW +: DW]), .i_pop(w_in_pop[c]),
            .o_dout(w_in_dout[c]), .o_cnt(w_in_cnt[c]),
            .o_full(w_in_full[c]), .o_empty(w_in_empty[c])
        );

        assign to_user_valid[c]           = !w_out_empty[c];
        assign to_user_data[c*DW +: DW]   = w_out_empty[c] ? '0 : w_out_dout[c];
        assign from_user_ready[c]         = !w_in_full[c];
        assign w_status[c] = DW'({6'b0, r_unf, r_ovf, 6'b0, w_in_empty[c], w_out_full[c],
                                  8'(w_in_cnt[c]), 8'(w_out_cnt[c])});

        // A same-cycle error event wins over a clear so the flag is never silently lost.
        always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
            if (!rst_main_n_sync) begin
                r_ovf <= 1'b0;
                r_unf <= 1'b0;
            end else begin
                if (w_wr_ctrl && wdata[0]) begin
                    r_ovf <= 1'b0;
                    r_unf <= 1'b0;
                end
                if (w_wr_data && w_out_full[c])  r_ovf <= 1'b1;
                if (w_rd_hit && w_in_empty[c])   r_unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) r_state <= S_IDLE;
        else                  r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (arvalid_q) w_state_nxt = S_RESP;
            S_RESP:  if (rready)    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_main_a0 or negedge rst_main_n_sync) begin
        if (!rst_main_n_sync) begin
            r_rdata <= '0;
            r_rresp <= 2'b00;
        end else if (w_rd_acc) begin
            r_rdata <= w_resp_data;
            r_rresp <= w_resp_err ? 2'b10 : 2'b00;
        end
    end

    assign rvalid = (r_state == S_RESP);
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;
endmodule

// File: tb/tb_fifo_mailbox_bridge.sv
// Directed bench for fifo_mailbox_bridge: register vector table plus
// hand-written sequences for overflow, underflow, stall, flush and wrap.

module tb_fifo_mailbox_bridge;
    localparam int NCH = 2;
    localparam int DW  = 32;
    localparam logic [31:0] A0 = 32'h0000_0510;
    localparam logic [31:0] A1 = 32'h0000_0520;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wready = 1'b0;
    logic [31:0]       wr_addr = '0;
    logic [DW-1:0]     wdata = '0;
    logic              arvalid_q = 1'b0;
    logic [31:0]       araddr_q = '0;
    logic              rready = 1'b0;
    logic              rvalid;
    logic [DW-1:0]     rdata;
    logic [1:0]        rresp;
    logic [NCH-1:0]    to_user_valid;
    logic [NCH*DW-1:0] to_user_data;
    logic [NCH-1:0]    to_user_ready = '0;
    logic [NCH-1:0]    from_user_valid = '0;
    logic [NCH*DW-1:0] from_user_data = '0;
    logic [NCH-1:0]    from_user_ready;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    fifo_mailbox_bridge #(.NCH(NCH), .DW(DW), .DEPTH(16)) dut (
        .clk_main_a0(clk), .rst_main_n_sync(rst_n),
        .wready(wready), .wr_addr(wr_addr), .wdata(wdata),
        .arvalid_q(arvalid_q), .araddr_q(araddr_q), .rready(rready),
        .rvalid(rvalid), .rdata(rdata), .rresp(rresp),
        .to_user_valid(to_user_valid), .to_user_data(to_user_data), .to_user_ready(to_user_ready),
        .from_user_valid(from_user_valid), .from_user_data(from_user_data),
        .from_user_ready(from_user_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        wready = 1'b1; wr_addr = a; wdata = d;
        @(negedge clk);
        wready = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r);
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = a;
        @(negedge clk);
        arvalid_q = 1'b0;
        chk("rd_latency", 32'(rvalid), 32'd1);
        d = rdata; r = rresp;
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    task automatic push_in(input int ch, input logic [31:0] d);
        @(negedge clk);
        from_user_valid[ch] = 1'b1;
        from_user_data[ch*DW +: DW] = d;
        @(negedge clk);
        from_user_valid[ch] = 1'b0;
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
    } vec_t;

    vec_t vt[15];

    initial begin
        logic [31:0] d;
        logic [1:0]  r;

        vt[0]  = '{1'b0, A0 + 32'd4, 32'h0,  32'h0002_0000, 2'b00};
        vt[1]  = '{1'b0, A1 + 32'd4, 32'h0,  32'h0002_0000, 2'b00};
        vt[2]  = '{1'b0, 32'h0600,   32'h0,  32'haaaa_aaaa, 2'b10};
        vt[3]  = '{1'b0, A0 + 32'd8, 32'h0,  32'haaaa_aaaa, 2'b10};
        vt[4]  = '{1'b0, 32'h0512,   32'h0,  32'haaaa_aaaa, 2'b10};
        vt[5]  = '{1'b1, A0,         32'h11, 32'h0,         2'b00};
        vt[6]  = '{1'b0, A0 + 32'd4, 32'h0,  32'h0002_0001, 2'b00};
        vt[7]  = '{1'b1, A0 + 32'd4, 32'h5,  32'h0,         2'b00};
        vt[8]  = '{1'b0, A0 + 32'd4, 32'h0,  32'h0002_0001, 2'b00};
        vt[9]  = '{1'b0, A0,         32'h0,  32'hdead_0000, 2'b00};
        vt[10] = '{1'b0, A0 + 32'd4, 32'h0,  32'h0202_0001, 2'b00};
        vt[11] = '{1'b1, A0 + 32'd8, 32'h1,  32'h0,         2'b00};
        vt[12] = '{1'b0, A0 + 32'd4, 32'h0,  32'h0002_0001, 2'b00};
        vt[13] = '{1'b1, A0 + 32'd8, 32'h2,  32'h0,         2'b00};
        vt[14] = '{1'b0, A0 + 32'd4, 32'h0,  32'h0002_0000, 2'b00};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_tu_valid", 32'(to_user_valid), 32'd0);
        chk("rst_tu_data_lo", to_user_data[31:0], 32'd0);
        chk("rst_tu_data_hi", to_user_data[63:32], 32'd0);
        chk("rst_fu_ready", 32'(from_user_ready), 32'd3);

        for (int i = 0; i < 15; i++) begin
            if (vt[i].wr) begin
                wr(vt[i].addr, vt[i].data);
            end else begin
                rd(vt[i].addr, d, r);
                chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_d);
                chk($sformatf("vec%0d_rresp", i), 32'(r), 32'(vt[i].exp_r));
            end
        end

        // Overflow: 17 writes into a 16-deep FIFO, then drain in order.
        for (int i = 1; i <= 17; i++) wr(A0, 32'(i));
        chk("ovf_tu_valid", 32'(to_user_valid), 32'd1);
        rd(A0 + 32'd4, d, r);
        chk("ovf_status", d, 32'h0103_0010);
        @(negedge clk);
        to_user_ready[0] = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("drain_%0d", i), to_user_data[31:0], 32'(i));
            @(negedge clk);
        end
        to_user_ready[0] = 1'b0;
        chk("drain_empty_valid", 32'(to_user_valid), 32'd0);
        chk("drain_empty_data", to_user_data[31:0], 32'd0);

        // Inbound channel 1 reads, then underflow.
        push_in(1, 32'hcafe_0001);
        push_in(1, 32'hcafe_0002);
        rd(A1, d, r);
        chk("in1_first", d, 32'hcafe_0001);
        rd(A1, d, r);
        chk("in1_second", d, 32'hcafe_0002);
        rd(A1, d, r);
        chk("in1_empty", d, 32'hdead_0000);
        chk("in1_empty_resp", 32'(r), 32'd0);
        rd(A1 + 32'd4, d, r);
        chk("in1_unf_status", d, 32'h0202_0000);

        // Stalled SLVERR response; a stray read in RESP must not disturb it.
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = 32'h0600;
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = A0 + 32'd4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            arvalid_q = 1'b0;
            chk("stall_rvalid", 32'(rvalid), 32'd1);
            chk("stall_rdata", rdata, 32'haaaa_aaaa);
            chk("stall_rresp", 32'(rresp), 32'd2);
        end
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
        chk("stall_release", 32'(rvalid), 32'd0);

        // Fill both channel-0 FIFOs, set flags, then clear+flush.
        rd(A0, d, r);
        for (int i = 0; i < 17; i++) wr(A0, 32'h200 + 32'(i));
        @(negedge clk);
        from_user_valid[0] = 1'b1;
        for (int i = 0; i < 16; i++) begin
            from_user_data[31:0] = 32'h300 + 32'(i);
            @(negedge clk);
        end
        from_user_valid[0] = 1'b0;
        chk("fill_fu_ready", 32'(from_user_ready), 32'd2);
        rd(A0 + 32'd4, d, r);
        chk("fill_status", d, 32'h0301_1010);
        for (int i = 0; i < 3; i++) wr(A1, 32'h400 + 32'(i));
        wr(A0 + 32'd8, 32'd3);
        rd(A0 + 32'd4, d, r);
        chk("flush_status0", d, 32'h0002_0000);
        chk("flush_fu_ready", 32'(from_user_ready), 32'd3);
        chk("flush_tu_valid", 32'(to_user_valid), 32'd2);
        rd(A1 + 32'd4, d, r);
        chk("flush_status1", d, 32'h0202_0003);
        wr(A1 + 32'd8, 32'd3);
        rd(A1 + 32'd4, d, r);
        chk("flush1_status", d, 32'h0002_0000);

        // Streaming at half-full: push and pop every cycle across pointer wrap.
        for (int i = 0; i < 8; i++) wr(A0, 32'h100 + 32'(i));
        @(negedge clk);
        for (int k = 0; k < 100; k++) begin
            wready = 1'b1; wr_addr = A0; wdata = 32'h108 + 32'(k);
            to_user_ready[0] = 1'b1;
            chk("stream_head", to_user_data[31:0], 32'h100 + 32'(k));
            @(negedge clk);
        end
        wready = 1'b0;
        to_user_ready[0] = 1'b0;
        rd(A0 + 32'd4, d, r);
        chk("stream_count", d, 32'h0002_0008);

        // Reset during an outstanding response aborts it.
        @(negedge clk);
        arvalid_q = 1'b1; araddr_q = A0 + 32'd4;
        @(negedge clk);
        arvalid_q = 1'b0;
        chk("abort_pre_rvalid", 32'(rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rvalid", 32'(rvalid), 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_tu_valid", 32'(to_user_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd(A0 + 32'd4, d, r);
        chk("abort_status", d, 32'h0002_0000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
